// File: rtl/ei_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-stage pipelined 8x8 multiplier among NREQ requesters.
// Optional EI_ARB_PERF_EN adds perf_grants/perf_stalls counters.
module ei_mult_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              mult_en,
  output logic [7:0]        mult_a,
  output logic [7:0]        mult_b,
  input  logic [15:0]       mult_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
  output logic [2:0]        inflight
`ifdef EI_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grants,
  output logic [31:0]       perf_stalls
`endif
);

  logic [3:0]             r_tag_v;
  logic [3:0][IDW-1:0]    r_tag_id;
  logic [IDW-1:0]         r_last;
  logic [2:0]             r_inflight;

  logic                   w_en;
  logic                   w_gnt_any;
  logic [IDW-1:0]         w_gnt_id;
  logic [IDW-1:0]         w_idx;

  // Validity comes only from the tags, so the multiplier itself needs no reset.
  assign w_en      = ~r_tag_v[3] | rsp_ready;
  assign mult_en   = w_en;
  assign rsp_valid = r_tag_v[3];
  assign rsp_id    = r_tag_id[3];
  assign rsp_data  = mult_c;
  assign inflight  = r_inflight;

  // Search last+1 .. last+NREQ (mod NREQ); first valid requester wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    if (w_en) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        w_idx = IDW'((32'(r_last) + k) % NREQ);
        if (!w_gnt_any && req_valid[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_id  = w_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mult_a    = '0;
    mult_b    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt_any && (w_gnt_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        mult_a       = req_a[8*i +: 8];
        mult_b       = req_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_inflight <= '0;
    end else if (w_en) begin
      r_tag_v    <= {r_tag_v[2:0], w_gnt_any};
      r_tag_id   <= {r_tag_id[2:0], w_gnt_id};
      r_inflight <= r_inflight + 3'(w_gnt_any) - 3'(r_tag_v[3]);
      if (w_gnt_any) r_last <= w_gnt_id;
    end
  end

`ifdef EI_ARB_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      r_perf_grants <= r_perf_grants + 32'(w_gnt_any);
      r_perf_stalls <= r_perf_stalls + 32'(~w_en);
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_ei_mult_arbiter.sv
// Self-checking bench for ei_mult_arbiter with a behavioural 4-stage multiplier and an in-order scoreboard.
module tb_ei_mult_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              mult_en;
  logic [7:0]        mult_a;
  logic [7:0]        mult_b;
  logic [15:0]       mult_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;
  logic [2:0]        inflight;
`ifdef EI_ARB_PERF_EN
  logic [31:0]       perf_grants;
  logic [31:0]       perf_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  ei_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mult_en   (mult_en),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_c    (mult_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .inflight  (inflight)
`ifdef EI_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  // Behavioural multiplier: 4 register stages, all gated by mult_en.
  logic [15:0] m_s0, m_s1, m_s2, m_s3;
  always @(posedge sys_clk) begin
    if (mult_en) begin
      m_s0 <= 16'(mult_a) * 16'(mult_b);
      m_s1 <= m_s0;
      m_s2 <= m_s1;
      m_s3 <= m_s2;
    end
  end
  assign mult_c = m_s3;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    p;
  } sb_t;
  sb_t q[$];

  // Scoreboard: push on accept, pop on response handshake.
  always @(negedge sys_clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      check("inflight_vs_sb", 32'(inflight), 32'(q.size()));
      check("stall_rule", 32'(mult_en), 32'(!rsp_valid || rsp_ready));
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("ready_implies_valid", 32'(req_ready & ~req_valid), 32'd0);
      if (req_ready == '0) check("idle_operands", 32'({mult_a, mult_b}), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_data), 32'd0);
          n_fail += (rsp_data == 16'd0) ? 1 : 0;
        end else begin
          sb_t e;
          e = q.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_data", 32'(rsp_data), 32'(e.p));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_t n;
          n.id = IDW'(i);
          n.p  = 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8]);
          q.push_back(n);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic reset_dut();
    nxt();
    rst = 1'b0;
    @(negedge sys_clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mult_en", 32'(mult_en), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    nxt();
    rst = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] acc;
    logic            got;
    int              eid[5];
    int              edat[5];

    tbl[0] = '{0, 8'd255, 8'd255, 16'd65025};
    tbl[1] = '{1, 8'd0,   8'd200, 16'd0};
    tbl[2] = '{2, 8'd255, 8'd1,   16'd255};
    tbl[3] = '{3, 8'd16,  8'd16,  16'd256};
    tbl[4] = '{0, 8'd15,  8'd17,  16'd255};
    tbl[5] = '{1, 8'd128, 8'd2,   16'd256};

    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Single request
    reset_dut();
    set_op(0, 8'd3, 8'd5);
    req_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      if (c == 0) check("t1_ready", 32'(req_ready), 32'd1);
      check("t1_rsp_valid", 32'(rsp_valid), 32'(c == 4));
      if (c == 4) begin
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_data", 32'(rsp_data), 32'd15);
      end
      check("t1_inflight", 32'(inflight), 32'(c >= 1 && c <= 4));
      nxt();
      if (c == 0) req_valid = '0;
    end

    // All four from reset
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'd10);
    req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      @(negedge sys_clk);
      check("t2_grant", 32'(req_ready), (c < 4) ? (32'd1 << c) : 32'd0);
      check("t2_rsp_valid", 32'(rsp_valid), 32'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) begin
        check("t2_rsp_id", 32'(rsp_id), 32'(c - 4));
        check("t2_rsp_data", 32'(rsp_data), 32'(10 * (c - 3)));
      end
      acc = req_valid & req_ready;
      nxt();
      req_valid = req_valid & ~acc;
    end

    // Fairness: 1 and 3 continuously valid
    set_op(1, 8'd7, 8'd9);
    set_op(3, 8'd11, 8'd13);
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      check("t3_alternate", 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
      nxt();
    end
    req_valid = '0;
    repeat (8) nxt();

    // Backpressure with a request waiting during the stall
    eid  = '{0, 1, 2, 3, 2};
    edat = '{14, 24, 36, 50, 300};
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 7), 8'(i + 2));
    req_valid = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      if (c == 4) begin
        rsp_ready = 1'b0;
        set_op(2, 8'd100, 8'd3);
        req_valid[2] = 1'b1;
      end
      if (c == 7) rsp_ready = 1'b1;
      @(negedge sys_clk);
      if (c < 4) check("t4_grant", 32'(req_ready), 32'd1 << c);
      if (c >= 4 && c <= 6) begin
        check("t4_hold_valid", 32'(rsp_valid), 32'd1);
        check("t4_hold_id", 32'(rsp_id), 32'd0);
        check("t4_hold_data", 32'(rsp_data), 32'd14);
        check("t4_no_grant", 32'(req_ready), 32'd0);
        check("t4_mult_en", 32'(mult_en), 32'd0);
      end
      if (c == 7) check("t4_resume_grant", 32'(req_ready), 32'h4);
      if (c >= 7 && c <= 11) begin
        check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4_rsp_id", 32'(rsp_id), 32'(eid[c - 7]));
        check("t4_rsp_data", 32'(rsp_data), 32'(edat[c - 7]));
      end
      if (c == 12) check("t4_drained", 32'(rsp_valid), 32'd0);
      acc = req_valid & req_ready;
      nxt();
      req_valid = req_valid & ~acc;
    end

    // Table of operand boundaries, one operation at a time
    for (int t = 0; t < 6; t++) begin
      set_op(tbl[t].id, tbl[t].a, tbl[t].b);
      req_valid = 4'(1 << tbl[t].id);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge sys_clk);
        if (req_ready[tbl[t].id]) got = 1'b1;
        nxt();
      end
      check("tbl_accept", 32'(got), 32'd1);
      req_valid = '0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge sys_clk);
        if (rsp_valid) begin
          check("tbl_id", 32'(rsp_id), 32'(tbl[t].id));
          check("tbl_data", 32'(rsp_data), 32'(tbl[t].exp));
          got = 1'b1;
        end
        nxt();
      end
      check("tbl_rsp_seen", 32'(got), 32'd1);
    end

    // Reset mid-flight with three ops in the pipeline
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 20), 8'd3);
    req_valid = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      acc = req_valid & req_ready;
      nxt();
      req_valid = req_valid & ~acc;
    end
    check("t6_pre_valid", 32'(rsp_valid), 32'd1);
    check("t6_pre_inflight", 32'(inflight), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_inflight", 32'(inflight), 32'd0);
    nxt();
    nxt();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      check("t6_no_stale_rsp", 32'(rsp_valid), 32'd0);
      nxt();
    end
    req_valid = 4'b1111;
    @(negedge sys_clk);
    check("t6_first_grant", 32'(req_ready), 32'd1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge sys_clk);
      acc = req_valid & req_ready;
      nxt();
      req_valid = req_valid & ~acc;
    end
    check("final_sb_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ei_mult_arbiter.md
# ei_mult_arbiter

Round-robin arbiter and sequencer that shares one pipelined 8x8 unsigned multiplier (`ei_multiplier`, 4 register stages) among NREQ requesters. It sits beside the multiplier in the MAC datapath. It grants at most one operand pair per cycle, drives the multiplier's operand and enable inputs, and tracks each in-flight operation with a tag pipeline aligned to the multiplier stages. It returns each product with the requester id over a valid/ready response port, stalling the whole pipeline under backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester id
- sys_clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  8*NREQ  operand A, requester i at [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- mult_en  out  1  enable to the multiplier (all stages)
- mult_a  out  8  operand A to the multiplier a_in
- mult_b  out  8  operand B to the multiplier b_in
- mult_c  in  16  product from the multiplier c_out
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  IDW  requester that issued the product
- rsp_data  out  16  product (= mult_c)
- inflight  out  3  number of valid tags in the pipeline (0..4)

## Operation
- Tag pipeline: 4 stages {valid, id}, shifting only when mult_en=1, matching the multiplier's register stages.
  - Stage 0 captures the grant; stage 3 drives rsp_valid and rsp_id.
- Stall rule: mult_en = ~rsp_valid | rsp_ready.
  - When mult_en=0, no grant is issued, req_ready=0, and all tags and multiplier stages hold.
- Arbitration:
  - Round-robin pointer `last` holds the id of the last grant.
  - Search order is last+1, last+2, … wrapping modulo NREQ.
  - The first requester with req_valid=1 wins when mult_en=1.
  - The winner gets req_ready[i]=1 combinationally in the same cycle; a transfer is valid&ready.
  - `last` updates to the winner on that edge.
- mult_a/mult_b = req_a/req_b slice of the winner.
  - With no winner they are 0 and stage 0 captures valid=0, a bubble.
- Products: unsigned, full 16 bits, no saturation; 255*255=65025.
- inflight = count of valid tags, registered, updated with the tag pipeline.
- A requester holding req_valid must keep its operands stable until req_ready; the block does not latch unaccepted operands.

## Timing
- Reset values:
  - req_ready=0, mult_en=1, rsp_valid=0, rsp_id=0, inflight=0.
  - All tag valid bits 0.
  - last=NREQ-1, so requester 0 has first priority.
- Latency: accept in cycle t gives rsp_valid=1 in cycle t+4 when no stall occurs. Each stall cycle adds one.
- Throughput: one accept per cycle; back-to-back responses when rsp_ready=1.
- rsp_valid/rsp_id/rsp_data hold stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous accept and response in one cycle is allowed (the pipeline shifts).
- Reset mid-operation clears all tags.
  - Multiplier register contents are then don't-care; no stale product is ever presented, because validity comes only from the tags.
- Responses leave in accept order; no reordering.

## Configuration
- EI_ARB_PERF_EN defined:
  - Adds outputs perf_grants (32 bits, counts accepts) and perf_stalls (32 bits, counts cycles with mult_en=0).
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Single request:
  - Stimulus: req0 with a=3, b=5 at cycle 0, rsp_ready=1.
  - Required: req_ready[0]=1 in cycle 0; rsp_valid=1, rsp_id=0, rsp_data=15 in cycle 4 only; inflight rises to 1 and returns to 0.
- All four requesters valid together from reset, operands a=i+1, b=10:
  - Required: grants in order 0,1,2,3 on consecutive cycles.
  - Required: responses 10, 20, 30, 40 with ids 0..3 in cycles 4..7.
- Fairness:
  - Stimulus: req1 and req3 continuously valid.
  - Required: grants alternate 1,3,1,3; neither starves.
- Backpressure:
  - Stimulus: 4 ops in flight, rsp_ready=0 for 3 cycles after the first rsp_valid.
  - Required: rsp_data held, req_ready all 0, mult_en=0, no loss; all four products are delivered in order once ready returns.
- Boundary values:
  - Stimulus: a=255, b=255, then a=0, b=200.
  - Required: 65025 then 0.
- Reset mid-flight:
  - Stimulus: rst asserted with 3 ops in flight.
  - Required: rsp_valid=0 and inflight=0 immediately; no response appears after release; the first post-reset grant goes to requester 0.
